pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters, one per line as name, default, meaning:
  - PC_W, 32, PC and address width in bits.
  - RAS_DEPTH, 8, return-address stack entries (power of 2, at least 2).
  - RESET_PC, 0, PC value after reset.
REQ-002 Ports, one per line as name, direction, width, meaning:
  - clk, in, 1, sole clock, rising edge.
  - rst_n, in, 1, asynchronous active-low reset.
  - pc_src, in, 2, next-PC select: 00 seq, 01 jump, 10 branch, 11 return.
  - pc_write, in, 1, PC update strobe from the multicycle control FSM.
  - push_ret, in, 1, link request (JAL); honoured only with pc_src=01.
  - branch_offset, in, PC_W, signed byte offset, already sign-extended.
  - jump_target, in, PC_W, absolute jump address.
  - pc, out, PC_W, current PC (registered).
  - pc_plus4, out, PC_W, pc+4 (combinational).
  - ras_count, out, clog2(RAS_DEPTH)+1, valid stack entries.
  - ras_empty, out, 1, ras_count==0.
  - ras_full, out, 1, ras_count==RAS_DEPTH.
  - ras_err, out, 1, sticky overflow/underflow flag.

Function
REQ-003 State SHALL change only on a clk edge with pc_write=1; with pc_write=0, pc, stack and ras_err SHALL hold, and push_ret and pc_src SHALL be ignored.
REQ-004 pc_src=00 SHALL load pc+4.
REQ-005 pc_src=01 SHALL load jump_target.
REQ-006 pc_src=10 SHALL load pc+branch_offset.
REQ-007 pc_src=11 SHALL pop the stack top into pc.
REQ-008 All adds SHALL be modulo 2^PC_W; wrap-around is silent, with no flag.
REQ-009 Bits [1:0] of every loaded PC SHALL be forced to 00.
REQ-010 Latency SHALL be exactly one cycle: the new pc is visible the cycle after the pc_write edge.
REQ-011 pc_src=01 with push_ret=1 SHALL push the pre-update pc+4 and load jump_target in the same edge.
REQ-012 Push when full SHALL discard the oldest entry (circular), keep ras_count=RAS_DEPTH, and set ras_err.
REQ-013 Pop when empty SHALL load pc+4 instead, leave ras_count=0, and set ras_err.
REQ-014 Push and pop SHALL be mutually exclusive by encoding; push_ret with pc_src≠01 SHALL be ignored.
REQ-015 Stack storage SHALL be LIFO: top = last pushed, non-evicted entry.
REQ-016 ras_err SHALL clear only on reset.

Reset
REQ-017 On rst_n=0, asynchronously: pc=RESET_PC, ras_count=0, ras_err=0, stack pointer=0.
REQ-018 Stack entry contents need not reset.
REQ-019 Reset SHALL override a pc_write in the same cycle.
REQ-020 The first update after rst_n deasserts SHALL use the first clk edge with pc_write=1.

Structure
REQ-021 A shared package SHALL hold the pc_src encodings (PCSRC_SEQ=00, PCSRC_JMP=01, PCSRC_BR=10, PCSRC_RET=11), common to the PC source decoder and this block.
REQ-022 The return stack SHALL be a sub-module pc_ras with:
  - ports push, pop, push_data, top, count, full, empty, err;
  - circular pointer with overwrite.
REQ-023 Next-PC mux, adders and pc register SHALL sit in pc_sequencer.

Verification
REQ-024 Sequential and hold: reset, then 3 pc_write pulses with pc_src=00 -> pc=0x0,0x4,0x8,0xC; pc_write=0 for 5 cycles -> pc stays 0xC.
REQ-025 Branch and wrap: pc=0x100, branch_offset=0xFFFFFFF0 -> pc=0xF0; pc=0xFFFFFFFC with pc_src=00 -> pc=0x0, ras_err=0.
REQ-026 Call/return: pc=0x20, pc_src=01, push_ret=1, jump_target=0x400 -> pc=0x400, ras_count=1; then pc_src=11 -> pc=0x24, ras_empty=1.
REQ-027 Overflow and underflow:
  - 9 linked jumps from pc=0x10,0x14,...,0x30 -> ras_full=1, ras_err=1;
  - 8 pops return 0x34 down to 0x18 (0x14 evicted);
  - a 9th pop -> pc=old pc+4.
REQ-028 Async reset mid-operation: rst_n low between edges with ras_count=3 -> pc=RESET_PC and ras_count=0 immediately, with no clk edge; a coincident pc_write is ignored.
REQ-029 Ignored push: push_ret=1 with pc_src=10 -> branch taken, ras_count unchanged.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg
// Purpose : Shared definitions for the PC sequencing logic. Holds the pc_src
//           encodings that the PC source decoder drives and that
//           pc_sequencer consumes. Also holds a small helper that recognises
//           a linking jump.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

  // Next-PC source select encodings
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_JMP = 2'b01;
  localparam logic [1:0] PCSRC_BR  = 2'b10;
  localparam logic [1:0] PCSRC_RET = 2'b11;

  // A link is only meaningful on a jump. On every other source the
  // push_ret request is dropped, so pushes and pops can never collide.
  function automatic logic is_link(input logic [1:0] pc_src, input logic push_ret);
    return push_ret && (pc_src == PCSRC_JMP);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras
// Purpose : Return-address stack with a circular pointer. A push onto a full
//           stack overwrites the oldest entry. A pop from an empty stack
//           leaves the stack untouched. Both of these cases set the sticky
//           err flag, which only reset clears.
// Ports   : clk, rst_n        - clock, async active-low reset
//           push, pop         - stack operations (push has priority if both)
//           push_data         - value written on push
//           top               - most recent non-evicted entry
//           count             - number of valid entries (0..DEPTH)
//           full, empty, err  - status; err is sticky over/underflow
// ---------------------------------------------------------------------------
module pc_ras #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ptr_q always points at the next free slot. Because DEPTH is a power of
  // two, the pointer wraps naturally. After DEPTH pushes, the slot it
  // points to holds the oldest entry, which is exactly the one to evict.
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] top_idx;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign err     = err_q;
  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = mem_q[top_idx];

  // Pointer, occupancy and error bookkeeping for push/pop.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (full) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        ptr_d   = ptr_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage has no reset. An entry is only ever read after it has
  // been written, because count gates every pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Purpose : Program counter for a multicycle core. Selects the next PC from
//           sequential, jump, branch or return sources. The PC updates on a
//           clk edge with pc_write=1. A return-address stack supplies
//           return targets and is pushed by linking jumps.
// Ports   : clk, rst_n      - clock, async active-low reset
//           pc_src         - 00 seq, 01 jump, 10 branch, 11 return
//           pc_write       - PC update strobe
//           push_ret       - link request (only with pc_src=01)
//           branch_offset  - sign-extended byte offset
//           jump_target    - absolute jump address
//           pc, pc_plus4   - registered PC and its +4 successor
//           ras_count/empty/full/err - return stack status
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 pc_src,
  input  logic                       pc_write,
  input  logic                       push_ret,
  input  logic [PC_W-1:0]            branch_offset,
  input  logic [PC_W-1:0]            jump_target,
  output logic [PC_W-1:0]            pc,
  output logic [PC_W-1:0]            pc_plus4,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_err
);

  // Clearing the low two bits keeps every loaded PC word aligned.
  localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] branch_pc;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] ras_top;
  logic            do_push;
  logic            do_pop;

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + PC_W'(4);
  assign branch_pc = pc_q + branch_offset;

  assign do_push = pc_write && is_link(pc_src, push_ret);
  assign do_pop  = pc_write && (pc_src == PCSRC_RET);

  // The link address is the pre-update pc+4. It is pushed on the same edge
  // that loads the jump target.
  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty),
    .err       (ras_err)
  );

  // Next-PC selection. A return on an empty stack falls through to pc+4.
  // The stack flags that underflow on its own.
  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src)
      PCSRC_SEQ: next_pc = pc_plus4;
      PCSRC_JMP: next_pc = jump_target;
      PCSRC_BR:  next_pc = branch_pc;
      PCSRC_RET: next_pc = ras_empty ? pc_plus4 : ras_top;
      default:   next_pc = pc_plus4;
    endcase
    pc_d = pc_write ? (next_pc & ALIGN_MASK) : pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. Directed call/return, wrap,
// overflow/underflow and reset scenarios are followed by randomized traffic.
// All traffic is compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rstN;
  logic [1:0]  pcSrc;
  logic        pcWrite;
  logic        pushRet;
  logic [31:0] branchOffset;
  logic [31:0] jumpTarget;
  logic [31:0] pcOut;
  logic [31:0] pcPlus4;
  logic [3:0]  rasCount;
  logic        rasEmpty;
  logic        rasFull;
  logic        rasErr;

  int checks   = 0;
  int failures = 0;

  // Reference model: the PC, a queue holding return addresses (back = top),
  // and the sticky error flag.
  logic [31:0] modelPc;
  logic [31:0] rasModel[$];
  logic        modelErr;

  pc_sequencer #(
    .PC_W      (32),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (32'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rstN),
    .pc_src        (pcSrc),
    .pc_write      (pcWrite),
    .push_ret      (pushRet),
    .branch_offset (branchOffset),
    .jump_target   (jumpTarget),
    .pc            (pcOut),
    .pc_plus4      (pcPlus4),
    .ras_count     (rasCount),
    .ras_empty     (rasEmpty),
    .ras_full      (rasFull),
    .ras_err       (rasErr)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point. It counts each comparison and reports any miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Clears the model, mirroring the effect of rst_n on the design.
  task automatic modelReset();
    modelPc  = 32'h0;
    modelErr = 1'b0;
    rasModel.delete();
  endtask

  // Applies the rules for one strobed update using plain arithmetic on the
  // queue. Pushing when full drops the oldest entry. Popping when empty
  // falls back to pc+4.
  task automatic modelStep(input logic [1:0] src, input logic wr, input logic push,
                           input logic [31:0] off, input logic [31:0] tgt);
    logic [31:0] nextPc;
    logic [31:0] link;
    if (!wr) return;
    link   = modelPc + 32'd4;
    nextPc = link;
    case (src)
      2'b00: nextPc = link;
      2'b01: begin
        if (push) begin
          if (rasModel.size() == DEPTH) begin
            void'(rasModel.pop_front());
            modelErr = 1'b1;
          end
          rasModel.push_back(link);
        end
        nextPc = tgt;
      end
      2'b10: nextPc = modelPc + off;
      default: begin
        if (rasModel.size() == 0) begin
          nextPc   = link;
          modelErr = 1'b1;
        end else begin
          nextPc = rasModel.pop_back();
        end
      end
    endcase
    modelPc = nextPc & 32'hFFFF_FFFC;
  endtask

  // Compares all visible outputs against the model.
  task automatic checkModel();
    checkOutput("pc", pcOut, modelPc);
    checkOutput("pc_plus4", pcPlus4, modelPc + 32'd4);
    checkOutput("ras_count", 32'(rasCount), 32'(rasModel.size()));
    checkOutput("ras_empty", 32'(rasEmpty), 32'(rasModel.size() == 0));
    checkOutput("ras_full", 32'(rasFull), 32'(rasModel.size() == DEPTH));
    checkOutput("ras_err", 32'(rasErr), 32'(modelErr));
  endtask

  // Drives one cycle of inputs at a falling edge, lets the rising edge act,
  // then checks at the next falling edge.
  task automatic applyStimulus(input logic [1:0] src, input logic wr, input logic push,
                               input logic [31:0] off, input logic [31:0] tgt);
    pcSrc        = src;
    pcWrite      = wr;
    pushRet      = push;
    branchOffset = off;
    jumpTarget   = tgt;
    modelStep(src, wr, push, off, tgt);
    @(posedge clk);
    @(negedge clk);
    checkModel();
  endtask

  task automatic jumpTo(input logic [31:0] addr);
    applyStimulus(PCSRC_JMP, 1'b1, 1'b0, 32'h0, addr);
  endtask

  // Directed scenarios first, then randomized traffic.
  initial begin
    rstN         = 1'b0;
    pcSrc        = PCSRC_SEQ;
    pcWrite      = 1'b0;
    pushRet      = 1'b0;
    branchOffset = 32'h0;
    jumpTarget   = 32'h0;
    modelReset();

    #12;
    checkOutput("reset_pc", pcOut, 32'h0);
    checkOutput("reset_count", 32'(rasCount), 32'h0);
    checkOutput("reset_empty", 32'(rasEmpty), 32'h1);
    checkOutput("reset_err", 32'(rasErr), 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Sequential steps, then holds with stray pc_src/push_ret values
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(PCSRC_SEQ, 1'b1, 1'b0, 32'h0, 32'h0);
      checkOutput("seq_pc", pcOut, 32'(4 * i));
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 1'b0, 1'b1, $urandom, $urandom);
      checkOutput("hold_pc", pcOut, 32'hC);
      checkOutput("hold_count", 32'(rasCount), 32'h0);
    end

    // Branch backwards, then wrap across the top of the address space
    jumpTo(32'h100);
    applyStimulus(PCSRC_BR, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    checkOutput("branch_back_pc", pcOut, 32'hF0);
    jumpTo(32'hFFFF_FFFC);
    applyStimulus(PCSRC_SEQ, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("wrap_pc", pcOut, 32'h0);
    checkOutput("wrap_err", 32'(rasErr), 32'h0);

    // Call and return
    jumpTo(32'h20);
    applyStimulus(PCSRC_JMP, 1'b1, 1'b1, 32'h0, 32'h400);
    checkOutput("call_pc", pcOut, 32'h400);
    checkOutput("call_count", 32'(rasCount), 32'h1);
    applyStimulus(PCSRC_RET, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("ret_pc", pcOut, 32'h24);
    checkOutput("ret_empty", 32'(rasEmpty), 32'h1);

    // push_ret alongside a branch must not touch the stack
    jumpTo(32'h80);
    applyStimulus(PCSRC_JMP, 1'b1, 1'b1, 32'h0, 32'h200);
    applyStimulus(PCSRC_BR, 1'b1, 1'b1, 32'h40, 32'h0);
    checkOutput("br_push_pc", pcOut, 32'h240);
    checkOutput("br_push_count", 32'(rasCount), 32'h1);
    applyStimulus(PCSRC_RET, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("br_push_ret_pc", pcOut, 32'h84);

    // Overflow with eviction of the oldest entry, then underflow
    jumpTo(32'h10);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(PCSRC_JMP, 1'b1, 1'b1, 32'h0, pcOut + 32'd4);
    end
    checkOutput("ovf_full", 32'(rasFull), 32'h1);
    checkOutput("ovf_err", 32'(rasErr), 32'h1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(PCSRC_RET, 1'b1, 1'b0, 32'h0, 32'h0);
      checkOutput("ovf_pop_pc", pcOut, 32'(32'h34 - 4 * i));
    end
    applyStimulus(PCSRC_RET, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("udf_pc", pcOut, 32'h1C);
    checkOutput("udf_count", 32'(rasCount), 32'h0);

    // Asynchronous reset between edges, with a pc_write pending
    for (int i = 0; i < 3; i++) begin
      applyStimulus(PCSRC_JMP, 1'b1, 1'b1, 32'h0, 32'h1000 + 32'(16 * i));
    end
    checkOutput("pre_rst_count", 32'(rasCount), 32'h3);
    pcSrc   = PCSRC_SEQ;
    pcWrite = 1'b1;
    #2 rstN = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_pc", pcOut, 32'h0);
    checkOutput("async_rst_count", 32'(rasCount), 32'h0);
    checkOutput("async_rst_err", 32'(rasErr), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_override_pc", pcOut, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(PCSRC_SEQ, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("post_rst_pc", pcOut, 32'h4);

    // Randomized traffic, biased towards strobed updates
    for (int i = 0; i < 300; i++) begin
      logic [31:0] off;
      int          smallOff;
      smallOff = int'($urandom_range(0, 1023)) - 512;
      off      = ($urandom_range(0, 7) == 0) ? $urandom : 32'(smallOff);
      applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 8),
                    1'($urandom_range(0, 1)), off, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
